mc_datapath: RTL and testbench

Multi-cycle MIPS-subset core: the parametrised successor to the single-cycle datapath. Each instruction runs through a FETCH/DECODE/EXEC/MEM/WB state machine and reuses one ALU and one memory port. A req/ready handshake to a unified instruction/data memory tolerates any number of wait states. The block holds PC, IR, the 32x32 register file, ALU and control, and sits directly under the system top next to the memory model.

---
 rtl/mc_datapath.sv | 231 +++++++++++++++++++++++
 tb/tb_mc_datapath.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_datapath.sv
// rtl/mc_datapath.sv - multi-cycle MIPS-subset core with a single req/ready memory port
// FETCH/DECODE/EXEC/MEM/WB sequencing around one ALU, PC/IR and a 32x32 register file.
module mc_datapath #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter logic [4:0]  JAL_REG         = 5'd31,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc_out,
  output logic        instr_done,
  output logic        halted
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t state, state_n;

  logic [31:0] pc, ir, a, b, alu_out, mdr;
  logic [31:0] rf [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, branch_target, jump_target;
  logic [31:0] rs_val, rt_val, r_result;
  logic        r_legal, op_legal;

  logic        req_c, we_c, done_c;
  logic [31:0] addr_c;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign op            = ir[31:26];
  assign rs            = ir[25:21];
  assign rt            = ir[20:16];
  assign rd            = ir[15:11];
  assign funct         = ir[5:0];
  assign imm_sext      = {{16{ir[15]}}, ir[15:0]};
  assign branch_target = pc + {imm_sext[29:0], 2'b00};
  assign jump_target   = {pc[31:28], ir[25:0], 2'b00};
  assign rs_val        = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rt_val        = (rt == 5'd0) ? 32'd0 : rf[rt];

  always_comb begin
    r_result = 32'd0;
    r_legal  = 1'b1;
    case (funct)
      FN_ADD:  r_result = a + b;
      FN_SUB:  r_result = a - b;
      FN_AND:  r_result = a & b;
      FN_OR:   r_result = a | b;
      FN_SLT:  r_result = {31'd0, $signed(a) < $signed(b)};
      default: r_legal  = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      OP_RTYPE: op_legal = r_legal;
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL: op_legal = 1'b1;
      default:  op_legal = 1'b0;
    endcase
  end

  // Next state and memory-port controls; everything here is a function of state only
  // (plus mem_ready for completion), so address and direction hold across wait states.
  always_comb begin
    state_n = state;
    req_c   = 1'b0;
    we_c    = 1'b0;
    addr_c  = 32'd0;
    done_c  = 1'b0;
    case (state)
      S_FETCH: begin
        req_c  = 1'b1;
        addr_c = {pc[31:2], 2'b00};
        if (mem_ready) state_n = S_DECODE;
      end
      S_DECODE: begin
        if (op_legal) begin
          state_n = S_EXEC;
        end else if (HALT_ON_ILLEGAL) begin
          state_n = S_HALT;
        end else begin
          done_c  = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_EXEC: begin
        case (op)
          OP_RTYPE, OP_ADDI: state_n = S_WB;
          OP_LW, OP_SW:      state_n = S_MEM;
          default: begin
            done_c  = 1'b1;
            state_n = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        req_c  = 1'b1;
        we_c   = (op == OP_SW);
        addr_c = {alu_out[31:2], 2'b00};
        if (mem_ready) begin
          if (op == OP_SW) begin
            done_c  = 1'b1;
            state_n = S_FETCH;
          end else begin
            state_n = S_WB;
          end
        end
      end
      S_WB: begin
        done_c  = 1'b1;
        state_n = S_FETCH;
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_FETCH;
    endcase
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (state == S_EXEC && op == OP_JAL) begin
      rf_we    = 1'b1;
      rf_waddr = JAL_REG;
      rf_wdata = pc;
    end else if (state == S_WB) begin
      rf_we = 1'b1;
      case (op)
        OP_RTYPE: begin rf_waddr = rd; rf_wdata = alu_out; end
        OP_ADDI:  begin rf_waddr = rt; rf_wdata = alu_out; end
        OP_LW:    begin rf_waddr = rt; rf_wdata = mdr;     end
        default:  rf_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      ir      <= 32'd0;
      a       <= 32'd0;
      b       <= 32'd0;
      alu_out <= 32'd0;
      mdr     <= 32'd0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        S_DECODE: begin
          a       <= rs_val;
          b       <= rt_val;
          alu_out <= branch_target;
        end
        S_EXEC: begin
          case (op)
            OP_RTYPE:            alu_out <= r_result;
            OP_ADDI, OP_LW, OP_SW: alu_out <= a + imm_sext;
            OP_BEQ:              if (a == b) pc <= alu_out;
            OP_BNE:              if (a != b) pc <= alu_out;
            OP_J, OP_JAL:        pc <= jump_target;
            default:             ;
          endcase
        end
        S_MEM: begin
          if (mem_ready && op == OP_LW) mdr <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (rf_we && rf_waddr != 5'd0) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

  assign mem_req    = reset & req_c;
  assign mem_we     = reset & we_c;
  assign mem_addr   = reset ? addr_c : 32'd0;
  assign mem_wdata  = (reset && state == S_MEM && op == OP_SW) ? b : 32'd0;
  assign instr_done = reset & done_c;
  assign halted     = (state == S_HALT);
  assign pc_out     = pc;

endmodule

// File: tb/tb_mc_datapath.sv
// tb/tb_mc_datapath.sv - bench for mc_datapath: ISA-level reference model, random waits
// Directed program followed by a random instruction block, then illegal-opcode halt and resets.
module tb_mc_datapath;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req, mem_we, instr_done, halted;
  logic [31:0] mem_addr, mem_wdata, pc_out;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;

  mc_datapath #(
    .RESET_PC(RST_PC),
    .JAL_REG(5'd31),
    .HALT_ON_ILLEGAL(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .pc_out(pc_out),
    .instr_done(instr_done),
    .halted(halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int n_retired = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // tmem is what the DUT sees; m_mem/m_rf/m_pc are the architectural reference.
  logic [31:0] tmem  [1024];
  logic [31:0] m_mem [1024];
  logic [31:0] m_rf  [32];
  logic [31:0] m_pc;
  logic        e_valid, e_halt, e_store;
  int          e_cycles;
  logic [31:0] e_next_pc, e_daddr, e_ddata;

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    tmem[addr[11:2]]  = word;
    m_mem[addr[11:2]] = word;
  endtask

  task automatic m_reset();
    m_pc = RST_PC;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    e_valid = 1'b0;
    e_halt  = 1'b0;
    e_store = 1'b0;
  endtask

  // Executes the instruction at m_pc in one step and records what the DUT should do.
  task automatic model_step();
    logic [31:0] ins, pc4, sx, va, vb, res;
    logic [5:0]  op, fn;
    int          rs, rt, rd, wreg;
    logic        wr;
    ins = m_mem[m_pc[11:2]];
    pc4 = m_pc + 32'd4;
    op = ins[31:26]; fn = ins[5:0];
    rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
    sx = {{16{ins[15]}}, ins[15:0]};
    va = m_rf[rs]; vb = m_rf[rt];
    e_valid = 1'b1; e_halt = 1'b0; e_store = 1'b0;
    e_next_pc = pc4; e_cycles = 0; wr = 1'b0; wreg = 0; res = 32'd0;
    case (op)
      6'h00: begin
        e_cycles = 4; wr = 1'b1; wreg = rd;
        case (fn)
          6'h20: res = va + vb;
          6'h22: res = va - vb;
          6'h24: res = va & vb;
          6'h25: res = va | vb;
          6'h2A: res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
          default: begin wr = 1'b0; e_valid = 1'b0; e_halt = 1'b1; end
        endcase
      end
      6'h08: begin e_cycles = 4; wr = 1'b1; wreg = rt; res = va + sx; end
      6'h23: begin
        e_cycles = 5; e_daddr = (va + sx) & 32'hFFFF_FFFC;
        res = m_mem[e_daddr[11:2]]; wr = 1'b1; wreg = rt;
      end
      6'h2B: begin
        e_cycles = 4; e_store = 1'b1; e_daddr = (va + sx) & 32'hFFFF_FFFC;
        e_ddata = vb; m_mem[e_daddr[11:2]] = vb;
      end
      6'h04: begin e_cycles = 3; if (va == vb) e_next_pc = pc4 + (sx << 2); end
      6'h05: begin e_cycles = 3; if (va != vb) e_next_pc = pc4 + (sx << 2); end
      6'h02: begin e_cycles = 3; e_next_pc = {pc4[31:28], ins[25:0], 2'b00}; end
      6'h03: begin
        e_cycles = 3; e_next_pc = {pc4[31:28], ins[25:0], 2'b00};
        wr = 1'b1; wreg = 31; res = pc4;
      end
      default: begin e_valid = 1'b0; e_halt = 1'b1; end
    endcase
    if (wr && wreg != 0) m_rf[wreg] = res;
    if (e_valid) m_pc = e_next_pc;
  endtask

  // Memory responder and per-instruction scoreboard, evaluated on the falling edge.
  initial begin : responder
    int          wait_left, acc_waits, icyc, acc_idx, cur_mode;
    logic        chk_pc, cap_we;
    logic [31:0] cap_addr, cap_wd;
    logic [9:0]  idx;
    wait_left = -1; acc_waits = 0; icyc = 0; acc_idx = 0; cur_mode = 0; chk_pc = 1'b0;
    cap_we = 1'b0; cap_addr = 32'd0; cap_wd = 32'd0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mem_ready = 1'b0;
        wait_left = -1; acc_waits = 0; icyc = 0; acc_idx = 0; chk_pc = 1'b0;
        continue;
      end
      if (halted) begin
        mem_ready = 1'($urandom_range(0, 1));
        continue;
      end
      if (chk_pc) begin
        check("pc_out", pc_out, e_next_pc);
        chk_pc = 1'b0;
      end
      icyc++;
      if (mem_req) begin
        if (wait_left < 0) begin
          if (acc_idx == 0) begin
            if (m_pc >= 32'h100 && m_pc < 32'h114)      cur_mode = 0;
            else if (m_pc >= 32'h114 && m_pc < 32'h11C) cur_mode = 2;
            else                                         cur_mode = 3;
          end
          wait_left = (cur_mode == 3) ? int'($urandom_range(0, 3)) : cur_mode;
          acc_waits += wait_left;
          cap_addr = mem_addr; cap_we = mem_we; cap_wd = mem_wdata;
          if (acc_idx == 0) begin
            check("fetch_addr", mem_addr, m_pc);
            check("fetch_we", 32'(mem_we), 32'd0);
          end else if (e_store) begin
            check("st_we", 32'(mem_we), 32'd1);
            check("st_addr", mem_addr, e_daddr);
            check("st_data", mem_wdata, e_ddata);
          end else begin
            check("ld_we", 32'(mem_we), 32'd0);
            check("ld_addr", mem_addr, e_daddr);
          end
        end else begin
          check("hold_addr", mem_addr, cap_addr);
          check("hold_we", 32'(mem_we), 32'(cap_we));
          check("hold_wdata", mem_wdata, cap_wd);
        end
        if (wait_left > 0) begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          wait_left--;
        end else begin
          mem_ready = 1'b1;
          idx = mem_addr[11:2];
          if (mem_we) tmem[idx] = mem_wdata;
          else        mem_rdata = tmem[idx];
          if (acc_idx == 0) model_step();
          acc_idx++;
          wait_left = -1;
        end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      #1;
      if (instr_done) begin
        n_retired++;
        check("done_expected", 32'(e_valid), 32'd1);
        check("cycles", 32'(icyc), 32'(e_cycles + acc_waits));
        chk_pc = 1'b1;
        icyc = 0; acc_waits = 0; acc_idx = 0; e_valid = 1'b0;
      end
    end
  end

  initial begin : main
    int          reqs, target;
    logic [5:0]  fns [5];
    logic [31:0] a;
    int          k;
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
    for (int i = 0; i < 1024; i++) begin tmem[i] = 32'd0; m_mem[i] = 32'd0; end

    put(32'h100, enc_i(6'h08, 0, 1, 16'd5));
    put(32'h104, enc_i(6'h08, 0, 2, 16'hFFFD));
    put(32'h108, enc_r(1, 2, 3, 6'h20));
    put(32'h10C, enc_r(2, 1, 4, 6'h22));
    put(32'h110, enc_r(2, 1, 5, 6'h2A));
    put(32'h114, enc_i(6'h2B, 0, 3, 16'd8));
    put(32'h118, enc_i(6'h23, 0, 6, 16'd8));
    put(32'h11C, enc_i(6'h2B, 0, 4, 16'd12));
    put(32'h120, enc_i(6'h2B, 0, 5, 16'd16));
    put(32'h124, enc_i(6'h2B, 0, 6, 16'd20));
    put(32'h128, enc_i(6'h08, 0, 0, 16'd7));
    put(32'h12C, enc_r(0, 0, 1, 6'h20));
    put(32'h130, enc_i(6'h2B, 0, 1, 16'd24));
    put(32'h134, enc_i(6'h08, 0, 8, 16'd2));
    put(32'h138, enc_i(6'h04, 7, 8, 16'd2));
    put(32'h13C, enc_i(6'h08, 7, 7, 16'd1));
    put(32'h140, enc_i(6'h05, 7, 8, 16'hFFFE));
    put(32'h144, enc_j(6'h02, 26'h10));
    put(32'h040, enc_j(6'h03, 26'h80));
    put(32'h200, enc_i(6'h2B, 0, 31, 16'd28));
    a = 32'h204;
    for (int n = 0; n < 60; n++) begin
      k = int'($urandom_range(0, 9));
      if (k <= 3)
        put(a, enc_r(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)), fns[$urandom_range(0, 4)]));
      else if (k <= 5)
        put(a, enc_i(6'h08, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 16'($urandom)));
      else if (k == 6)
        put(a, enc_i(6'h23, 0, int'($urandom_range(0, 7)), 16'(32'h800 + $urandom_range(0, 1023))));
      else if (k == 7)
        put(a, enc_i(6'h2B, 0, int'($urandom_range(0, 7)), 16'(32'h800 + $urandom_range(0, 1023))));
      else
        put(a, enc_i((k == 8) ? 6'h04 : 6'h05, int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)), 16'($urandom_range(0, 3))));
      a += 32'd4;
    end
    for (int n = 0; n < 5; n++) begin
      put(a, 32'hFC00_0000);
      a += 32'd4;
    end
    m_reset();

    repeat (3) @(negedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_instr_done", 32'(instr_done), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc_out", pc_out, RST_PC);
    #1 reset = 1'b1;

    for (int i = 0; i < 20000 && !halted; i++) @(negedge clk);
    check("halt_reached", 32'(halted), 32'd1);
    check("model_halt", 32'(e_halt), 32'd1);
    reqs = 0;
    repeat (20) begin
      @(negedge clk);
      #2;
      if (mem_req) reqs++;
    end
    check("halt_mem_req", 32'(reqs), 32'd0);
    check("halt_hold", 32'(halted), 32'd1);

    check("mem_add", tmem[2], 32'd2);
    check("mem_sub", tmem[3], 32'hFFFF_FFF8);
    check("mem_slt", tmem[4], 32'd1);
    check("mem_lw", tmem[5], 32'd2);
    check("mem_r0", tmem[6], 32'd0);
    check("mem_jal", tmem[7], 32'h0000_0044);

    @(negedge clk);
    #2 reset = 1'b0;
    m_reset();
    #1;
    check("rst2_mem_req", 32'(mem_req), 32'd0);
    check("rst2_halted", 32'(halted), 32'd0);
    check("rst2_pc_out", pc_out, RST_PC);
    @(negedge clk);
    #2 reset = 1'b1;
    target = n_retired + 3;
    for (int i = 0; i < 200 && n_retired < target; i++) @(negedge clk);
    check("restart_retired", 32'(n_retired >= target), 32'd1);

    for (int i = 0; i < 50 && !mem_req; i++) @(negedge clk);
    #2 reset = 1'b0;
    m_reset();
    #1;
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_pc_out", pc_out, RST_PC);
    @(negedge clk);
    #2 reset = 1'b1;
    target = n_retired + 2;
    for (int i = 0; i < 200 && n_retired < target; i++) @(negedge clk);
    check("abort_retired", 32'(n_retired >= target), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
